// File: rtl/adc_frontend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_frontend_pkg
//  Brief    : Shared constants and types for the ADC measurement front end:
//             controller Q-format widths, FSM state encoding and default
//             sample geometry.
//  Revision : 1.0 - initial release
// ============================================================================
package adc_frontend_pkg;

   // Controller fixed-point format: signed Q32.32 held as [32:-32]
   localparam int bits_enteros = 32;
   localparam int bits_decimal = 32;

   // Default raw sample width and averaging depth
   localparam int DEF_ADC_W    = 12;
   localparam int DEF_AVG_LOG2 = 3;

   // Period sequencer states
   typedef enum logic [1:0] {
      ACC = 2'd0,   // accumulate samples
      SC1 = 2'd1,   // mean and offset removal
      SC2 = 2'd2,   // gain multiply
      PUB = 2'd3    // publish outputs
   } state_t;

endpackage : adc_frontend_pkg
`default_nettype wire

// File: rtl/adc_scale.sv
`default_nettype none
// ============================================================================
//  Module   : adc_scale
//  Brief    : Per-channel conversion of an accumulated sample sum into a
//             signed Q32.32 voltage: mean -> minus offset -> times Q16.16 gain.
//             Two register stages (difference, product); enabled by ce.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_scale
   import adc_frontend_pkg::*;
#(
   parameter int                ADC_W    = DEF_ADC_W,
   parameter int                AVG_LOG2 = DEF_AVG_LOG2,
   parameter logic [ADC_W-1:0]  OFFSET   = '0,
   parameter logic signed [31:0] GAIN    = 32'sh0001_0000
) (
   input  logic                                    clk,
   input  logic                                    rst,   // active-low, async
   input  logic                                    ce,
   input  logic [ADC_W+AVG_LOG2-1:0]               acc,
   output logic signed [bits_enteros:-bits_decimal] vdc
);

   localparam int PROD_W   = ADC_W + 33;            // Q(ADC_W+17).16
   localparam int EXT_W    = bits_enteros + 1 + 16; // integer part + 16 fraction bits
   localparam int FRAC_PAD = bits_decimal - 16;     // unused low fraction bits

   logic [ADC_W-1:0]        mean;
   logic signed [ADC_W:0]   diff_d, diff_q;
   logic signed [PROD_W-1:0] diff_ext, gain_ext;
   logic signed [PROD_W-1:0] prod_d, prod_q;
   logic signed [EXT_W-1:0]  prod_sext;

   // Arithmetic pipeline next-state and Q32.32 re-alignment of the product
   always_comb begin
      mean      = ADC_W'(acc >> AVG_LOG2);
      diff_ext  = PROD_W'(diff_q);
      gain_ext  = PROD_W'(GAIN);
      diff_d    = diff_q;
      prod_d    = prod_q;
      if (ce) begin
         diff_d = $signed({1'b0, mean}) - $signed({1'b0, OFFSET});
         prod_d = diff_ext * gain_ext;
      end
      prod_sext = EXT_W'(prod_q);
      vdc       = {prod_sext, {FRAC_PAD{1'b0}}};
   end

   // Pipeline registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         diff_q <= '0;
         prod_q <= '0;
      end else begin
         diff_q <= diff_d;
         prod_q <= prod_d;
      end
   end

endmodule : adc_scale
`default_nettype wire

// File: rtl/adc_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : adc_frontend
//  Brief    : DC-link measurement front end. Accumulates 2^AVG_LOG2 raw ADC
//             samples per channel (Vdc1/Vdc2), scales them to signed Q32.32
//             volts and publishes on the actuator period trigger.
//             Optional macro ADC_FRONTEND_OVP_EN adds a sticky over-voltage
//             flag against VMAX; without it ovp is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_frontend
   import adc_frontend_pkg::*;
#(
   parameter int                 ADC_W    = DEF_ADC_W,
   parameter int                 AVG_LOG2 = DEF_AVG_LOG2,
   parameter logic [ADC_W-1:0]   OFFSET1  = '0,
   parameter logic [ADC_W-1:0]   OFFSET2  = '0,
   parameter logic signed [31:0] GAIN1    = 32'sh0001_0000,
   parameter logic signed [31:0] GAIN2    = 32'sh0001_0000,
   parameter logic [31:0]        VMAX     = 32'd1000
) (
   input  logic                                    clk,
   input  logic                                    rst,        // active-low, async
   input  logic                                    CE,
   input  logic                                    trigger,
   input  logic                                    s_valid,
   output logic                                    s_ready,
   input  logic                                    s_chan,
   input  logic [ADC_W-1:0]                        s_data,
   output logic signed [bits_enteros:-bits_decimal] Vdc1,
   output logic signed [bits_enteros:-bits_decimal] Vdc2,
   output logic                                    data_valid,
   output logic                                    stale,
   output logic                                    ovp
);

   localparam int              ACC_W  = ADC_W + AVG_LOG2;
   localparam int              CNT_W  = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0] N_SAMP = CNT_W'(1) << AVG_LOG2;

   state_t                                  state_q, state_d;
   logic [ACC_W-1:0]                        acc1_q, acc1_d, acc2_q, acc2_d;
   logic [CNT_W-1:0]                        cnt1_q, cnt1_d, cnt2_q, cnt2_d;
   logic signed [bits_enteros:-bits_decimal] vdc1_q, vdc1_d, vdc2_q, vdc2_d;
   logic signed [bits_enteros:-bits_decimal] scaled1, scaled2;
   logic                                    data_valid_q, data_valid_d;
   logic                                    stale_q, stale_d;
   logic                                    hs;

   adc_scale #(
      .ADC_W    (ADC_W),
      .AVG_LOG2 (AVG_LOG2),
      .OFFSET   (OFFSET1),
      .GAIN     (GAIN1)
   ) u_scale1 (
      .clk (clk),
      .rst (rst),
      .ce  (CE),
      .acc (acc1_q),
      .vdc (scaled1)
   );

   adc_scale #(
      .ADC_W    (ADC_W),
      .AVG_LOG2 (AVG_LOG2),
      .OFFSET   (OFFSET2),
      .GAIN     (GAIN2)
   ) u_scale2 (
      .clk (clk),
      .rst (rst),
      .ce  (CE),
      .acc (acc2_q),
      .vdc (scaled2)
   );

   assign s_ready = CE && (state_q == ACC);
   // Pulse flops freeze while CE is low; masking keeps them invisible then
   assign data_valid = data_valid_q && CE;
   assign stale      = stale_q && CE;
   assign Vdc1       = vdc1_q;
   assign Vdc2       = vdc2_q;

   // Sample accumulation, period sequencing and publish next-state
   always_comb begin
      state_d      = state_q;
      acc1_d       = acc1_q;
      acc2_d       = acc2_q;
      cnt1_d       = cnt1_q;
      cnt2_d       = cnt2_q;
      vdc1_d       = vdc1_q;
      vdc2_d       = vdc2_q;
      data_valid_d = CE ? 1'b0 : data_valid_q;
      stale_d      = CE ? 1'b0 : stale_q;
      hs           = s_valid && s_ready;

      // Samples for a channel that is already full are accepted and dropped
      if (hs && !s_chan && (cnt1_q != N_SAMP)) begin
         acc1_d = acc1_q + ACC_W'(s_data);
         cnt1_d = cnt1_q + CNT_W'(1);
      end
      if (hs && s_chan && (cnt2_q != N_SAMP)) begin
         acc2_d = acc2_q + ACC_W'(s_data);
         cnt2_d = cnt2_q + CNT_W'(1);
      end

      if (CE) begin
         case (state_q)
            ACC: begin
               // Same-cycle sample already counted in cnt*_d
               if (trigger) begin
                  if ((cnt1_d == N_SAMP) && (cnt2_d == N_SAMP)) begin
                     state_d = SC1;
                  end else begin
                     stale_d = 1'b1;
                  end
               end
            end
            SC1: state_d = SC2;
            SC2: state_d = PUB;
            PUB: begin
               vdc1_d       = scaled1;
               vdc2_d       = scaled2;
               data_valid_d = 1'b1;
               acc1_d       = '0;
               acc2_d       = '0;
               cnt1_d       = '0;
               cnt2_d       = '0;
               state_d      = ACC;
            end
            default: state_d = ACC;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ACC;
         acc1_q       <= '0;
         acc2_q       <= '0;
         cnt1_q       <= '0;
         cnt2_q       <= '0;
         vdc1_q       <= '0;
         vdc2_q       <= '0;
         data_valid_q <= 1'b0;
         stale_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc1_q       <= acc1_d;
         acc2_q       <= acc2_d;
         cnt1_q       <= cnt1_d;
         cnt2_q       <= cnt2_d;
         vdc1_q       <= vdc1_d;
         vdc2_q       <= vdc2_d;
         data_valid_q <= data_valid_d;
         stale_q      <= stale_d;
      end
   end

`ifdef ADC_FRONTEND_OVP_EN
   logic ovp_q, ovp_d;

   // Sticky over-voltage: integer part of a freshly published value above VMAX
   always_comb begin
      ovp_d = ovp_q;
      if (CE && (state_q == PUB)) begin
         if (($signed(scaled1[bits_enteros:0]) > $signed({1'b0, VMAX})) ||
             ($signed(scaled2[bits_enteros:0]) > $signed({1'b0, VMAX}))) begin
            ovp_d = 1'b1;
         end
      end
   end

   // Over-voltage flag register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovp_q <= 1'b0;
      end else begin
         ovp_q <= ovp_d;
      end
   end

   assign ovp = ovp_q;
`else
   logic unused_vmax;
   assign unused_vmax = ^VMAX;
   assign ovp         = 1'b0;
`endif

endmodule : adc_frontend
`default_nettype wire

// File: tb/tb_adc_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_frontend
//  Brief    : Self-checking bench for adc_frontend. Directed period scenarios
//             followed by randomized sample/trigger traffic, compared against
//             a queue-based arithmetic model of the measurement chain.
//             Honours ADC_FRONTEND_OVP_EN for the ovp expectation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_frontend;

   localparam int                 ADC_W    = 12;
   localparam int                 AVG_LOG2 = 2;
   localparam int                 NS       = 4;
   localparam int                 OFF1     = 2048;
   localparam int                 OFF2     = 0;
   localparam logic signed [31:0] G1       = 32'sh0001_0000;  // 1.0
   localparam logic signed [31:0] G2       = 32'sh0001_4000;  // 1.25
   localparam logic [31:0]        VMAXP    = 32'd500;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    ce = 1'b1;
   logic                    trigger = 1'b0;
   logic                    s_valid = 1'b0;
   logic                    s_ready;
   logic                    s_chan = 1'b0;
   logic [ADC_W-1:0]        s_data = '0;
   logic signed [64:0]      vdc1, vdc2;
   logic                    data_valid, stale, ovp;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int                 q1[$];
   int                 q2[$];
   logic signed [64:0] m_vdc1 = '0;
   logic signed [64:0] m_vdc2 = '0;
   logic               m_ovp  = 1'b0;

   adc_frontend #(
      .ADC_W    (ADC_W),
      .AVG_LOG2 (AVG_LOG2),
      .OFFSET1  (ADC_W'(OFF1)),
      .OFFSET2  (ADC_W'(OFF2)),
      .GAIN1    (G1),
      .GAIN2    (G2),
      .VMAX     (VMAXP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .CE         (ce),
      .trigger    (trigger),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_chan     (s_chan),
      .s_data     (s_data),
      .Vdc1       (vdc1),
      .Vdc2       (vdc2),
      .data_valid (data_valid),
      .stale      (stale),
      .ovp        (ovp)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: mean of the first NS accepted samples of a channel
   function automatic int mean_of(input bit ch);
      int s = 0;
      for (int i = 0; i < NS; i++) s += ch ? q2[i] : q1[i];
      return s / NS;
   endfunction

   // Model: volts in Q.16 as plain integer arithmetic
   function automatic longint volts_q16(input int mean, input int off, input longint gain);
      return longint'(mean - off) * gain;
   endfunction

   function automatic logic signed [64:0] to_q3232(input longint p);
      logic signed [64:0] r;
      r = 65'(p);
      return r <<< 16;
   endfunction

   function automatic void model_accept(input bit ch, input int d);
      if (!ch && q1.size() < NS) q1.push_back(d);
      if (ch && q2.size() < NS) q2.push_back(d);
   endfunction

   task automatic send(input bit ch, input int d);
      s_valid = 1'b1;
      s_chan  = ch;
      s_data  = ADC_W'(d);
      check_eq("s_ready_acc", s_ready, 1'b1);
      tick();
      s_valid = 1'b0;
      model_accept(ch, d);
   endtask

   task automatic fill(input int d1, input int d2);
      for (int i = 0; i < NS; i++) begin
         send(1'b0, d1);
         send(1'b1, d2);
      end
   endtask

   // Trigger a period and follow it through to publish (or stale)
   task automatic do_trigger(input bit with_s, input bit ch, input int d,
                             input int stall, input bit extra_trig);
      longint p1, p2;
      trigger = 1'b1;
      if (with_s) begin
         s_valid = 1'b1;
         s_chan  = ch;
         s_data  = ADC_W'(d);
      end
      tick();
      trigger = 1'b0;
      s_valid = 1'b0;
      if (with_s) model_accept(ch, d);
      if (!(q1.size() == NS && q2.size() == NS)) begin
         check_eq("stale_pulse", stale, 1'b1);
         check_eq("dv_on_stale", data_valid, 1'b0);
         check_eq("vdc1_hold", vdc1, m_vdc1);
         check_eq("vdc2_hold", vdc2, m_vdc2);
         tick();
         check_eq("stale_one_cycle", stale, 1'b0);
         return;
      end
      check_eq("no_stale_go", stale, 1'b0);
      check_eq("s_ready_sc1", s_ready, 1'b0);
      if (stall > 0) begin
         ce = 1'b0;
         for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("s_ready_stall", s_ready, 1'b0);
            check_eq("dv_stall", data_valid, 1'b0);
         end
         ce = 1'b1;
      end
      trigger = extra_trig;
      tick();
      trigger = 1'b0;
      check_eq("dv_sc2", data_valid, 1'b0);
      check_eq("s_ready_sc2", s_ready, 1'b0);
      tick();
      check_eq("dv_pub", data_valid, 1'b0);
      check_eq("no_stale_busy", stale, 1'b0);
      tick();
      p1     = volts_q16(mean_of(1'b0), OFF1, longint'(G1));
      p2     = volts_q16(mean_of(1'b1), OFF2, longint'(G2));
      m_vdc1 = to_q3232(p1);
      m_vdc2 = to_q3232(p2);
`ifdef ADC_FRONTEND_OVP_EN
      if ((p1 >>> 16) > longint'(VMAXP) || (p2 >>> 16) > longint'(VMAXP)) m_ovp = 1'b1;
`endif
      q1.delete();
      q2.delete();
      check_eq("dv_publish", data_valid, 1'b1);
      check_eq("vdc1_publish", vdc1, m_vdc1);
      check_eq("vdc2_publish", vdc2, m_vdc2);
      check_eq("ovp_publish", ovp, m_ovp);
      check_eq("s_ready_back", s_ready, 1'b1);
      tick();
      check_eq("dv_one_cycle", data_valid, 1'b0);
   endtask

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_vdc1", vdc1, '0);
      check_eq("rst_vdc2", vdc2, '0);
      check_eq("rst_dv", data_valid, 1'b0);
      check_eq("rst_stale", stale, 1'b0);
      check_eq("rst_ovp", ovp, 1'b0);
      #3 rst = 1'b1;
      #1 check_eq("s_ready_after_rst", s_ready, 1'b1);
      tick();

      // Basic period: 100 on both channels
      fill(100, 100);
      do_trigger(1'b0, 1'b0, 0, 0, 1'b0);
      check_eq("plan_vdc2_125", vdc2, 65'sh7D_0000_0000);
      check_eq("plan_vdc1_m1948", vdc1, 65'h1_FFFF_F864_0000_0000);

      // Offset removal giving a negative result
      fill(1000, 100);
      do_trigger(1'b0, 1'b0, 0, 0, 1'b1);
      check_eq("plan_vdc1_m1048", vdc1, 65'h1_FFFF_FBE8_0000_0000);

      // Stale: Vdc1 one sample short, then completed on the trigger cycle
      for (int i = 0; i < 3; i++) send(1'b0, 300);
      for (int i = 0; i < 4; i++) send(1'b1, 400);
      do_trigger(1'b0, 1'b0, 0, 0, 1'b0);
      do_trigger(1'b1, 1'b0, 308, 0, 1'b0);

      // Over-voltage on Vdc2, then a quiet period
      fill(2048, 600);
      do_trigger(1'b0, 1'b0, 0, 0, 1'b0);
      fill(2048, 100);
      do_trigger(1'b0, 1'b0, 0, 0, 1'b0);
`ifdef ADC_FRONTEND_OVP_EN
      check_eq("ovp_sticky", ovp, 1'b1);
`else
      check_eq("ovp_tied_low", ovp, 1'b0);
`endif

      // CE stalled for 10 cycles in SC1
      fill(3000, 2000);
      do_trigger(1'b0, 1'b0, 0, 10, 1'b0);

      // Asynchronous reset during SC2
      fill(4000, 4000);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check_eq("rst_sc2_vdc1", vdc1, '0);
      check_eq("rst_sc2_vdc2", vdc2, '0);
      check_eq("rst_sc2_dv", data_valid, 1'b0);
      check_eq("rst_sc2_ovp", ovp, 1'b0);
      q1.delete();
      q2.delete();
      m_vdc1 = '0;
      m_vdc2 = '0;
      m_ovp  = 1'b0;
      tick();
      #2 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("no_dv_after_rst", data_valid, 1'b0);
      end
      fill(200, 300);
      do_trigger(1'b0, 1'b0, 0, 0, 1'b0);

      // Randomized periods
      for (int per = 0; per < 30; per++) begin
         int  n1, n2;
         bit  ch;
         n1 = $urandom_range(2, 6);
         n2 = $urandom_range(2, 6);
         while (n1 + n2 > 0) begin
            if (n1 == 0)      ch = 1'b1;
            else if (n2 == 0) ch = 1'b0;
            else              ch = 1'($urandom_range(0, 1));
            if (ch) n2--; else n1--;
            if ($urandom_range(0, 4) == 0) begin
               // CE-low cycle: nothing accepted, trigger ignored
               ce      = 1'b0;
               trigger = 1'($urandom_range(0, 1));
               s_valid = 1'b1;
               s_chan  = ch;
               s_data  = ADC_W'($urandom_range(0, 4095));
               #1 check_eq("s_ready_ce_low", s_ready, 1'b0);
               tick();
               ce      = 1'b1;
               trigger = 1'b0;
               s_valid = 1'b0;
               #1 check_eq("no_stale_ce_low", stale, 1'b0);
            end
            send(ch, int'($urandom_range(0, 4095)));
         end
         do_trigger(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4095)), 0, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_adc_frontend
`default_nettype wire
